// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block sequencer: word intake, 64-round control, chaining state
module sha256_round_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first,
    input  logic [31:0]  word_in,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [255:0] wv_in,
    output logic         rnd_load,
    output logic [255:0] h_out,
    output logic         rnd_en,
    output logic [5:0]   rnd_idx,
    output logic [31:0]  rnd_k,
    output logic [31:0]  rnd_d,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    localparam int ROUNDS = 64;
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
    localparam logic [5:0] WORD_CNT = 6'd16;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [5:0]   cnt;
    logic [255:0] h_q;
    logic [255:0] h_sum;
    logic [255:0] digest_q;
    logic         word_phase;

    assign word_phase = (cnt < WORD_CNT);

    // Per-word modular add; carries never cross the 32-bit word boundaries.
    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i*32 +: 32] = h_q[i*32 +: 32] + wv_in[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            h_q      <= '0;
            digest_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start && first) begin
                        h_q <= IV;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                end
                S_ROUND: begin
                    if (rnd_en) begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_FINAL: begin
                    h_q      <= h_sum;
                    digest_q <= h_sum;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        word_ready = 1'b0;
        rnd_en     = 1'b0;
        rnd_load   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                rnd_load = 1'b1;
                state_n  = S_ROUND;
            end
            S_ROUND: begin
                // Word phase advances only on a handshake; schedule phase free-runs.
                if (word_phase) begin
                    word_ready = 1'b1;
                    rnd_en     = word_valid;
                end else begin
                    rnd_en = 1'b1;
                end
                if (rnd_en && (cnt == LAST_IDX)) begin
                    state_n = S_FINAL;
                end
            end
            S_FINAL: begin
                state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign rnd_idx = cnt;
    assign rnd_k   = K_ROM[cnt];
    assign rnd_d   = word_phase ? word_in : 32'h0;
    assign h_out   = h_q;
    assign digest  = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - scoreboard bench for sha256_round_ctrl with a behavioural SHA-256 model
module tb_sha256_round_ctrl;

    typedef logic [31:0] blk_t [16];
    typedef struct {
        logic [255:0] dig;
        int           cyc;
    } exp_t;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         first;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic [255:0] wv_in;
    logic         rnd_load;
    logic [255:0] h_out;
    logic         rnd_en;
    logic [5:0]   rnd_idx;
    logic [31:0]  rnd_k;
    logic [31:0]  rnd_d;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    sha256_round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first      (first),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .wv_in      (wv_in),
        .rnd_load   (rnd_load),
        .h_out      (h_out),
        .rnd_en     (rnd_en),
        .rnd_idx    (rnd_idx),
        .rnd_k      (rnd_k),
        .rnd_d      (rnd_d),
        .busy       (busy),
        .done       (done),
        .digest     (digest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_total  = 0;
    int           n_pass   = 0;
    int           accepted = 0;
    int           dones    = 0;
    exp_t         sb[$];
    logic [255:0] ref_h = '0;
    logic [31:0]  dp [8];
    logic [31:0]  ws [16];

    assign wv_in = {dp[0], dp[1], dp[2], dp[3], dp[4], dp[5], dp[6], dp[7]};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction
    function automatic logic [31:0] ch(input logic [31:0] e, f, g); return (e & f) ^ (~e & g); endfunction
    function automatic logic [31:0] maj(input logic [31:0] a, b, c); return (a & b) ^ (a & c) ^ (b & c); endfunction

    // Whole-block SHA-256 compression from the algorithm definition.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input blk_t blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + bs1(v[4]) + ch(v[4], v[5], v[6]) + kt[t] + w[t];
            t2 = bs0(v[0]) + maj(v[0], v[1], v[2]);
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // Datapath stand-in plus monitor: advances a..h on each rnd_en and checks outputs.
    initial begin
        int           exp_idx;
        logic [31:0]  wt, t1, t2;
        exp_t         e;
        exp_idx = 0;
        for (int i = 0; i < 8; i++) dp[i] = '0;
        for (int i = 0; i < 16; i++) ws[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rnd_load) begin
                    for (int i = 0; i < 8; i++) dp[i] = h_out[255-32*i -: 32];
                    exp_idx = 0;
                end
                if (word_ready) chk("ready_in_word_phase", 256'(rnd_idx < 6'd16), 256'(1));
                if (rnd_en) begin
                    chk("rnd_idx", 256'(rnd_idx), 256'(exp_idx));
                    chk("rnd_k", 256'(rnd_k), 256'(kt[rnd_idx]));
                    chk("rnd_d", 256'(rnd_d), (rnd_idx < 6'd16) ? 256'(word_in) : 256'(0));
                    if (rnd_idx < 6'd16) wt = rnd_d;
                    else wt = ss1(ws[14]) + ws[9] + ss0(ws[1]) + ws[0];
                    for (int i = 0; i < 15; i++) ws[i] = ws[i+1];
                    ws[15] = wt;
                    t1 = dp[7] + bs1(dp[4]) + ch(dp[4], dp[5], dp[6]) + rnd_k + wt;
                    t2 = bs0(dp[0]) + maj(dp[0], dp[1], dp[2]);
                    dp[7] = dp[6]; dp[6] = dp[5]; dp[5] = dp[4]; dp[4] = dp[3] + t1;
                    dp[3] = dp[2]; dp[2] = dp[1]; dp[1] = dp[0]; dp[0] = t1 + t2;
                    exp_idx++;
                end
                if (done) begin
                    dones++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 256'(1), 256'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("digest", digest, e.dig);
                        chk("done_cycle", 256'(cyc), 256'(e.cyc));
                        chk("h_out_eq_digest", h_out, digest);
                    end
                end
            end
        end
    end

    task automatic run_block(input blk_t w, input bit f, input int nstall, input int abort_round, input bit poke);
        int   stall_at [16];
        int   k, g;
        exp_t e;
        for (int i = 0; i < 16; i++) stall_at[i] = 0;
        for (int i = 0; i < nstall; i++) stall_at[$urandom_range(0, 15)]++;
        e.dig = ref_compress(f ? IV : ref_h, w);
        ref_h = e.dig;
        @(posedge clk); #1;
        e.cyc = cyc + 67 + nstall;
        sb.push_back(e);
        accepted++;
        start = 1'b1;
        first = f;
        @(posedge clk); #1;
        start = 1'b0;
        first = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        k = 0;
        g = 0;
        while (k < 16 && g < 100) begin
            if (stall_at[k] > 0) begin
                word_valid = 1'b0;
                word_in    = $urandom;
                stall_at[k]--;
            end else begin
                word_valid = 1'b1;
                word_in    = w[k];
            end
            @(negedge clk);
            if (word_valid && word_ready) k++;
            @(posedge clk); #1;
            g++;
        end
        if (k < 16) fail("word_intake");
        word_valid = 1'($urandom_range(0, 1));
        word_in    = $urandom;
        if (abort_round >= 0) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!(rnd_en && rnd_idx == 6'(abort_round)) && g < 200);
            if (g >= 200) fail("abort_wait");
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_busy", 256'(busy), 256'(0));
            chk("abort_h_out", h_out, 256'(0));
            chk("abort_digest", digest, 256'(0));
            chk("abort_idx", 256'(rnd_idx), 256'(0));
            chk("abort_k", 256'(rnd_k), 256'h428a2f98);
            void'(sb.pop_back());
            accepted--;
            ref_h = '0;
            word_valid = 1'b0;
            return;
        end
        if (poke) begin
            start = 1'b1;
            first = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            first = 1'b0;
        end
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 200);
        if (!done) fail("done_wait");
        word_valid = 1'b0;
        if (poke) begin
            start = 1'b1;
            first = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            first = 1'b0;
            @(negedge clk);
            chk("start_in_done_ignored", 256'(busy), 256'(0));
            chk("h_kept_after_done", h_out, ref_h);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ref_h = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        blk_t abc, b1, b2, rb;
        abc = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        b1  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        b2  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
        reset      = 1'b1;
        start      = 1'b0;
        first      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_word_ready", 256'(word_ready), 256'(0));
        chk("rst_rnd_load", 256'(rnd_load), 256'(0));
        chk("rst_rnd_en", 256'(rnd_en), 256'(0));
        chk("rst_rnd_idx", 256'(rnd_idx), 256'(0));
        chk("rst_rnd_k", 256'(rnd_k), 256'h428a2f98);
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_h_out", h_out, 256'(0));
        @(posedge clk); #1 reset = 1'b0;

        run_block(abc, 1'b1, 0, -1, 1'b0);
        chk("abc_kat", digest, ABC_DIG);
        run_block(abc, 1'b1, 3, -1, 1'b0);
        chk("abc_stall_kat", digest, ABC_DIG);

        run_block(b1, 1'b1, 0, -1, 1'b0);
        run_block(b2, 1'b0, 2, -1, 1'b1);
        chk("two_block_kat", digest, TWO_DIG);

        run_block(abc, 1'b1, 0, 30, 1'b0);
        run_block(abc, 1'b1, 1, -1, 1'b0);
        chk("abc_after_abort_kat", digest, ABC_DIG);

        pulse_reset();
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        run_block(rb, 1'b0, 0, -1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) rb[i] = $urandom;
            run_block(rb, 1'($urandom_range(0, 1)), $urandom_range(0, 4), -1, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done_count", 256'(dones), 256'(accepted));
        chk("scoreboard_empty", 256'(sb.size()), 256'(0));
        chk("idle_at_end", 256'(busy), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for the SHA-256 compression datapath (message-schedule window plus a..h round registers). It accepts one 512-bit block as 16 handshaked 32-bit words and drives the datapath through 64 rounds, supplying round index, K constant and message word. It keeps the chaining state H0..H7 and performs the final H += working-variable addition. It sits between the padding/word source and the round datapath and presents the 256-bit digest plus a done pulse.

## Interface
- ROUNDS, 64, number of compression rounds; fixed by the algorithm and not to be overridden.
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin processing one block; sampled only in IDLE.
- FIRST  in  1  sampled with START; 1 = load standard IV into H0..H7, 0 = chain from current H0..H7.
- WORD_IN  in  32  message word, big-endian word order W0 first.
- WORD_VALID  in  1  WORD_IN valid.
- WORD_READY  out  1  controller accepts a word this cycle.
- WV_IN  in  256  datapath a..h; a at [255:224], h at [31:0].
- RND_LOAD  out  1  one-cycle pulse; datapath loads a..h from H_OUT.
- H_OUT  out  256  current H0..H7; H0 at [255:224].
- RND_EN  out  1  advance datapath one round this cycle.
- RND_IDX  out  6  round index of the current RND_EN.
- RND_K  out  32  K[RND_IDX] from internal 64-entry ROM.
- RND_D  out  32  WORD_IN when RND_IDX<16, else 0.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse; DIGEST updated.
- DIGEST  out  256  equals H_OUT; stable from DONE until the next block's FINAL.

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE: START=1 moves to LOAD. If FIRST=1, H0..H7 take IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) at the same edge.
- LOAD: RND_LOAD=1 for one cycle; round counter cleared to 0; next state ROUND.
- ROUND, idx<16:
  - WORD_READY=1.
  - RND_EN = WORD_VALID & WORD_READY. Counter increments only on a handshake.
  - WORD_VALID=0 stalls with RND_EN=0 and the counter held.
- ROUND, idx>=16: WORD_READY=0; RND_EN=1 every cycle.
- ROUND exit: on the RND_EN with idx=63, go to FINAL.
- FINAL:
  - Each Hi <= Hi + WV_IN word i, mod 2^32, no carry between words.
  - RND_EN=0; next state DONE.
- DONE: DONE=1 for one cycle; then IDLE.
- START outside IDLE is ignored, with no queuing.
- WORD_VALID outside word phase is ignored and WORD_READY stays 0.
- RESET:
  - State IDLE, counter 0, H0..H7 = 0.
  - All outputs 0: WORD_READY, RND_LOAD, RND_EN, RND_IDX, BUSY, DONE, DIGEST, H_OUT.
  - RND_K = K[0] (428a2f98) because RND_IDX=0.
  - Reset in any state, including mid-round, aborts the block. Nothing is written to H.
- START with FIRST=0 directly after reset chains from all-zero H. This is defined behaviour, not an error.

## Timing
- Cycle n: START sampled at edge n. n+1: LOAD. n+2..n+65: rounds 0..63 with no stalls. n+66: FINAL. n+67: DONE=1, DIGEST valid.
- Minimum START-to-DONE latency is 67 cycles. Each word-phase stall cycle adds 1.
- Earliest next START is accepted in the cycle after DONE, giving 68 cycles per block back-to-back.
- RND_IDX, RND_K and RND_D are combinational from the counter and WORD_IN. They are valid in the same cycle as RND_EN; the datapath registers on that edge.
- WV_IN is sampled in FINAL, one edge after the last RND_EN.
- BUSY rises at the edge after START and falls at the edge after DONE.

## Test plan
- Single block "abc" (W0=61626380, W1..W14=0, W15=00000018), FIRST=1, WORD_VALID always 1 -> DONE at cycle n+67; DIGEST = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block, WORD_VALID deasserted 3 random cycles during words -> RND_EN/counter frozen on stall cycles, DONE at n+70, identical digest.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 FIRST=1, block 2 FIRST=0 -> final DIGEST = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- RESET at round 30 -> next cycle BUSY=0, H_OUT=0, DIGEST=0; then rerun "abc" with FIRST=1 -> correct digest.
- START pulsed during ROUND and during DONE -> ignored; exactly one DONE per accepted START; RND_IDX sequence 0..63 without repeats.
- RND_K check across one block -> idx0=428a2f98, idx16=e49b69c1, idx63=c67178f2; RND_D=0 for idx>=16.
